// File: rtl/mem_stream_reader.sv
// mem_stream_reader: reads a block of synchronous RAM starting at a base
// address and streams the words out on a valid/ready interface. A 4-entry
// first-word-fall-through FIFO hides the 1-cycle RAM latency, and a read-credit
// rule keeps it from overflowing while still sustaining one word per clock.
module mem_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_rd_en;      // read issued this cycle
    logic              r_inflight;   // RAM data for last cycle's read is on mem_rd_data
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;  // reads still to issue after the current one

    logic [DATA_W-1:0] r_fifo [4];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_count;

    logic              w_launch;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_committed;

    // Words already in the FIFO plus reads whose data has not landed yet; a new
    // read is only scheduled while this stays below the FIFO depth.
    assign w_committed = r_count + {2'b00, r_rd_en} + {2'b00, r_inflight};
    assign w_launch    = (r_state == S_IDLE) && start && (length != '0);
    assign w_issue     = (r_state == S_READ) && (r_remaining != '0) && (w_committed < 3'd4);
    assign w_push      = r_inflight;
    assign w_pop       = out_valid && out_ready;

    assign mem_rd_en   = r_rd_en;
    assign mem_addr    = r_addr;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational;
        // a path that left w_next_state unassigned would infer a latch.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next_state = (length == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                if ((r_remaining == '0) ||
                    (w_issue && (r_remaining == {{ADDR_W{1'b0}}, 1'b1})))
                    w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_rd_en && !r_inflight &&
                    ((r_count == 3'd0) || ((r_count == 3'd1) && w_pop)))
                    w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state and FIFO occupancy.
    always_comb begin
        busy      = (r_state == S_READ) || (r_state == S_DRAIN);
        done      = (r_state == S_DONE);
        out_valid = (r_count != 3'd0);
        out_data  = out_valid ? r_fifo[r_rd_ptr] : '0;
    end

    // Read issue: registered strobe, address and remaining-read counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_en     <= 1'b0;
            r_inflight  <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            r_inflight <= r_rd_en;
            r_rd_en    <= w_launch || w_issue;
            if (w_launch) begin
                r_addr      <= base_addr;
                r_remaining <= length - (ADDR_W + 1)'(1);
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W + 1)'(1);
            end
        end
    end

    // FIFO storage: capture the RAM word the cycle after its read.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; r_count gates out_valid and
        // out_data, so stale entries are never visible.
        if (w_push) r_fifo[r_wr_ptr] <= mem_rd_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: drives bursts against a RAM preloaded with
// mem[a] = a ^ 8'hA5 and compares the read/stream activity against a
// transaction-level model (expected address/data queues, word occupancy).
module tb_mem_stream_reader;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, mem_rd_en, out_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    logic [DW-1:0] ram [256];

    int n_vec = 0;
    int n_err = 0;

    mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #10 clk = ~clk;

    // Synchronous RAM: one cycle read latency.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One burst. mode: 0 ready always 1, 1 ready toggling, 2 ready random.
    // Cycle t=0 is the cycle start is presented; outputs sampled at negedges.
    task automatic run_burst(input logic [7:0] base, input int len, input int mode,
                             input bit restart_mid);
        logic [7:0] exp_addr [$];
        logic [7:0] exp_data [$];
        logic [7:0] a;
        int  occ = 0, reads = 0, xfers = 0, last_xfer = -1, end_t = -1;
        int  bound = len * 8 + 40;
        bit  rd_prev = 0, rd_prev2 = 0, xfer_prev = 0, stall_prev = 0, first_seen = 0;
        bit  rdy, xfer, busy_exp, done_exp;
        logic [7:0] data_prev = '0;

        for (int i = 0; i < len; i++) begin
            a = base + 8'(i);
            exp_addr.push_back(a);
            exp_data.push_back(a ^ 8'hA5);
        end

        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        length    = 9'(len);
        out_ready = 1'b0;

        for (int t = 1; t <= bound; t++) begin
            @(negedge clk);
            if (t == 1) begin
                start     = 1'b0;
                base_addr = 8'($urandom);
                length    = 9'($urandom);
            end
            if (restart_mid && t == 3) begin
                start     = 1'b1;
                base_addr = 8'($urandom);
                length    = 9'($urandom_range(1, 200));
            end
            if (restart_mid && t == 4) start = 1'b0;

            // Words resident in the FIFO: land two cycles after their read.
            occ = occ + int'(rd_prev2) - int'(xfer_prev);
            check("valid_vs_occ", 32'(out_valid), 32'(occ != 0));
            check("occupancy_le_4", 32'(occ <= 4), 32'd1);

            if (mem_rd_en) begin
                reads++;
                if (exp_addr.size() == 0) check("extra_read", 32'(mem_addr), 32'hFFFF_FFFF);
                else                      check("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
            if (t == 1) check("first_rd_en", 32'(mem_rd_en), 32'(len != 0));
            if (out_valid && !first_seen) begin
                first_seen = 1;
                check("first_valid_time", t, 3);
            end
            if (stall_prev) check("stall_hold", 32'(out_data), 32'(data_prev));

            done_exp = (len == 0) ? (t == 1) : (xfers == len && t == last_xfer + 1);
            busy_exp = (len != 0) && !(xfers == len && t > last_xfer);
            check("done", 32'(done), 32'(done_exp));
            check("busy", 32'(busy), 32'(busy_exp));
            if (done_exp) end_t = t;

            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = t[0];
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = rdy;
            xfer = out_valid && rdy;
            if (xfer) begin
                if (exp_data.size() == 0) check("extra_xfer", 32'(out_data), 32'hFFFF_FFFF);
                else                      check("data", 32'(out_data), 32'(exp_data.pop_front()));
                xfers++;
                last_xfer = t;
            end

            stall_prev = out_valid && !rdy;
            data_prev  = out_data;
            rd_prev2   = rd_prev;
            rd_prev    = mem_rd_en;
            xfer_prev  = xfer;
            if (end_t >= 0 && t >= end_t + 3) break;
        end
        check("burst_terminated", 32'(end_t >= 0), 32'd1);
        check("read_count", reads, len);
        check("xfer_count", xfers, len);
        if (mode == 0 && len > 0) check("last_xfer_time", last_xfer, len + 2);
        out_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_rd_en"},     32'(mem_rd_en), 32'd0);
        check({tag, "_addr"},      32'(mem_addr),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
    endtask

    // Start a long stalled burst, reset it midway, then confirm it is gone.
    task automatic reset_mid_burst();
        @(negedge clk);
        start = 1'b1; base_addr = 8'h33; length = 9'd16; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("after_mid_reset");
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("aborted_done",  32'(done),      32'd0);
            check("aborted_busy",  32'(busy),      32'd0);
            check("aborted_valid", 32'(out_valid), 32'd0);
            check("aborted_rd_en", 32'(mem_rd_en), 32'd0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_burst(8'h10, 4, 0, 1'b0);
        run_burst(8'h00, 8, 1, 1'b0);
        run_burst(8'h77, 0, 0, 1'b0);
        run_burst(8'hFE, 4, 0, 1'b0);
        run_burst(8'h40, 12, 0, 1'b1);
        reset_mid_burst();
        run_burst(8'h20, 2, 0, 1'b0);
        run_burst(8'h80, 256, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_burst(8'($urandom), int'($urandom_range(1, 40)), 2, 1'b0);
        run_burst(8'hF0, 30, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
